// File: rtl/gs_butterfly_pkg.sv
// Shared constants and modular-arithmetic helpers for the NTT butterfly datapaths.
// Helpers work on a fixed wide word; callers zero-extend operands and truncate results.
package gs_butterfly_pkg;

   localparam int unsigned GsLatency = 4;
   localparam int unsigned MaxW      = 64;

   typedef logic [MaxW-1:0] word_t;

   // (a + b) mod q for a, b < q
   function automatic word_t mod_add(input word_t a, input word_t b, input word_t q);
      logic [MaxW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) begin
         s = s - {1'b0, q};
      end
      return MaxW'(s);
   endfunction

   // (a - b) mod q for a, b < q; the wrap of the fixed-width subtract is undone by adding q
   function automatic word_t mod_sub(input word_t a, input word_t b, input word_t q);
      return (a >= b) ? (a - b) : (a - b + q);
   endfunction

   // x * 2^-1 mod q for odd q: an odd x is made even by adding q before the shift
   function automatic word_t mod_halve(input word_t x, input word_t q);
      logic [MaxW:0] t;
      t = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
      return MaxW'(t >> 1);
   endfunction

endpackage

// File: rtl/barrett_reduce_pipe.sv
// Two-stage Barrett reduction of a 2n-bit product modulo q, with optional output halving.
// Stalls with en_i; the forward butterfly reuses it with halve_i tied low.
module barrett_reduce_pipe
   import gs_butterfly_pkg::*;
#(
   parameter int unsigned BitSize = 60
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 valid_i,
   input  logic [2*BitSize-1:0] p_i,
   input  logic [BitSize-1:0]   q_i,
   input  logic [BitSize:0]     mu_i,
   input  logic                 halve_i,
   output logic                 valid_o,
   output logic [BitSize-1:0]   r_o
);

   localparam int unsigned N = BitSize;

   logic           v3_q, h3_q, valid_q;
   logic [N:0]     qhat_d, qhat_q;
   logic [N+1:0]   p_lo_q;
   logic [N-1:0]   q3_q;
   logic [N+1:0]   q_ext, r0, r1, r2;
   logic [N-1:0]   r_n, r_d, r_q;

   assign q_ext = {2'b00, q3_q};

   // The remainder is below 3q < 2^(n+2), so only the low n+2 bits of P and qhat*q matter.
   always_comb begin
      qhat_d = (N+1)'(((2*N+2)'(p_i[2*N-1:N-1]) * (2*N+2)'(mu_i)) >> (N+1));
      r0     = p_lo_q - (N+2)'(qhat_q) * (N+2)'(q3_q);
      r1     = (r0 >= q_ext) ? (r0 - q_ext) : r0;
      r2     = (r1 >= q_ext) ? (r1 - q_ext) : r1;
      r_n    = N'(r2);
      r_d    = h3_q ? N'(mod_halve(word_t'(r_n), word_t'(q3_q))) : r_n;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v3_q    <= 1'b0;
         h3_q    <= 1'b0;
         qhat_q  <= '0;
         p_lo_q  <= '0;
         q3_q    <= '0;
         valid_q <= 1'b0;
         r_q     <= '0;
      end else if (en_i) begin
         v3_q    <= valid_i;
         h3_q    <= halve_i;
         qhat_q  <= qhat_d;
         p_lo_q  <= p_i[N+1:0];
         q3_q    <= q_i;
         valid_q <= v3_q;
         r_q     <= r_d;
      end
   end

   assign valid_o = valid_q;
   assign r_o     = r_q;

endmodule

// File: rtl/gs_butterfly.sv
// Gentleman-Sande inverse-NTT radix-2 butterfly: B0 = A0+A1, B1 = (A0-A1)*Y mod q, optional
// halving. Four-stage valid/ready pipeline; the whole pipe stalls when the output is blocked.
module gs_butterfly
   import gs_butterfly_pkg::*;
#(
   parameter int unsigned BitSize = 60
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [BitSize-1:0] a0_i,
   input  logic [BitSize-1:0] a1_i,
   input  logic [BitSize-1:0] y_i,
   input  logic [BitSize-1:0] q_i,
   input  logic [BitSize:0]   mu_i,
   input  logic               halve_i,
   output logic               out_valid_o,
   input  logic               out_ready_i,
   output logic [BitSize-1:0] b0_o,
   output logic [BitSize-1:0] b1_o
);

   localparam int unsigned N = BitSize;

   logic           adv;
   logic           v1_q, h1_q, v2_q, h2_q;
   logic [N-1:0]   b0_1_d, b0_1_q, d1_d, d1_q, y1_q, q1_q;
   logic [N:0]     mu1_q, mu2_q;
   logic [N-1:0]   b0_2_d, b0_2_q, q2_q, b0_3_q, b0_q;
   logic [2*N-1:0] p2_d, p2_q;

   assign adv        = ~out_valid_o | out_ready_i;
   assign in_ready_o = adv;

   always_comb begin
      b0_1_d = N'(mod_add(word_t'(a0_i), word_t'(a1_i), word_t'(q_i)));
      d1_d   = N'(mod_sub(word_t'(a0_i), word_t'(a1_i), word_t'(q_i)));
      p2_d   = (2*N)'(d1_q) * (2*N)'(y1_q);
      b0_2_d = h1_q ? N'(mod_halve(word_t'(b0_1_q), word_t'(q1_q))) : b0_1_q;
   end

   // q, mu and halve ride alongside their data so consecutive transactions may differ.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         v1_q   <= 1'b0;
         h1_q   <= 1'b0;
         b0_1_q <= '0;
         d1_q   <= '0;
         y1_q   <= '0;
         q1_q   <= '0;
         mu1_q  <= '0;
         v2_q   <= 1'b0;
         h2_q   <= 1'b0;
         b0_2_q <= '0;
         p2_q   <= '0;
         q2_q   <= '0;
         mu2_q  <= '0;
         b0_3_q <= '0;
         b0_q   <= '0;
      end else if (adv) begin
         v1_q   <= in_valid_i;
         h1_q   <= halve_i;
         b0_1_q <= b0_1_d;
         d1_q   <= d1_d;
         y1_q   <= y_i;
         q1_q   <= q_i;
         mu1_q  <= mu_i;
         v2_q   <= v1_q;
         h2_q   <= h1_q;
         b0_2_q <= b0_2_d;
         p2_q   <= p2_d;
         q2_q   <= q1_q;
         mu2_q  <= mu1_q;
         b0_3_q <= b0_2_q;
         b0_q   <= b0_3_q;
      end
   end

   barrett_reduce_pipe #(
      .BitSize(N)
   ) u_barrett (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (adv),
      .valid_i(v2_q),
      .p_i    (p2_q),
      .q_i    (q2_q),
      .mu_i   (mu2_q),
      .halve_i(h2_q),
      .valid_o(out_valid_o),
      .r_o    (b1_o)
   );

   assign b0_o = b0_q;

   // A blocked result must stay put until the consumer takes it.
   assert property (@(posedge clk_i) disable iff (!rst_ni)
      out_valid_o && !out_ready_i |=> out_valid_o && $stable(b0_o) && $stable(b1_o));

endmodule

// File: tb/tb_gs_butterfly.sv
// Self-checking bench for gs_butterfly: directed vectors, backpressure, reset, random soak
// at 8 and 60 bits against a plain modular-arithmetic reference.
module tb_gs_butterfly;
   import gs_butterfly_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic       in_valid, in_ready, out_valid, out_ready, halve;
   logic [7:0] a0, a1, y, q, b0, b1;
   logic [8:0] mu;

   logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_halve;
   logic [59:0] w_a0, w_a1, w_y, w_q, w_b0, w_b1;
   logic [60:0] w_mu;

   int n_cmp = 0;
   int n_bad = 0;
   int n_out8 = 0;
   logic last_in_ready;

   typedef struct packed {logic [127:0] b0; logic [127:0] b1;} exp_t;
   exp_t sb8[$];
   exp_t sb60[$];

   typedef struct {
      logic [7:0] a0, a1, y;
      logic       h;
      logic [7:0] b0, b1;
   } vec_t;
   vec_t vecs[9];

   gs_butterfly #(.BitSize(8)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .a0_i(a0), .a1_i(a1), .y_i(y), .q_i(q), .mu_i(mu), .halve_i(halve),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .b0_o(b0), .b1_o(b1)
   );

   gs_butterfly #(.BitSize(60)) u_dut60 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(w_in_valid), .in_ready_o(w_in_ready),
      .a0_i(w_a0), .a1_i(w_a1), .y_i(w_y), .q_i(w_q), .mu_i(w_mu), .halve_i(w_halve),
      .out_valid_o(w_out_valid), .out_ready_i(w_out_ready), .b0_o(w_b0), .b1_o(w_b1)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference straight from the definition; halving is multiplication by (q+1)/2.
   function automatic exp_t gs_ref(input logic [127:0] ra0, input logic [127:0] ra1,
                                   input logic [127:0] ry, input logic [127:0] rq,
                                   input logic rh);
      exp_t e;
      logic [127:0] inv2;
      inv2 = (rq + 1) >> 1;
      e.b0 = (ra0 + ra1) % rq;
      e.b1 = (((ra0 + rq - ra1) % rq) * ry) % rq;
      if (rh) begin
         e.b0 = (e.b0 * inv2) % rq;
         e.b1 = (e.b1 * inv2) % rq;
      end
      return e;
   endfunction

   task automatic new_vec8(input bit rand_q);
      if (rand_q) begin
         q  = {1'b1, 6'($urandom), 1'b1};
         mu = 9'(32'd65536 / 32'(q));
      end
      a0    = 8'($urandom_range(0, q - 1));
      a1    = 8'($urandom_range(0, q - 1));
      y     = 8'($urandom_range(0, q - 1));
      halve = 1'($urandom_range(0, 1));
   endtask

   function automatic logic [59:0] rnd60(input logic [59:0] m);
      logic [63:0] r;
      r = {$urandom, $urandom};
      return 60'(r % {4'b0, m});
   endfunction

   task automatic new_vec60();
      logic [63:0] r;
      r       = {$urandom, $urandom};
      w_q     = {1'b1, r[57:0], 1'b1};
      w_mu    = 61'((128'd1 << 120) / 128'(w_q));
      w_a0    = rnd60(w_q);
      w_a1    = rnd60(w_q);
      w_y     = rnd60(w_q);
      w_halve = 1'($urandom_range(0, 1));
   endtask

   // One clock of the 8-bit stream: score the consumed output, log the accepted input.
   task automatic cycle8(output logic acc);
      exp_t e;
      #1;
      last_in_ready = in_ready;
      check("in_ready8 rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
         n_out8++;
         if (sb8.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out8 unexpected: got output %0d/%0d, expected none", b0, b1);
         end else begin
            e = sb8.pop_front();
            check("b0_8 stream", b0, e.b0);
            check("b1_8 stream", b1, e.b1);
         end
      end
      acc = in_valid && in_ready;
      if (acc) sb8.push_back(gs_ref(a0, a1, y, q, halve));
      @(posedge clk);
      #1;
   endtask

   task automatic cycle60(output logic acc);
      exp_t e;
      #1;
      check("in_ready60 rule", w_in_ready, !w_out_valid || w_out_ready);
      if (w_out_valid && w_out_ready) begin
         if (sb60.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out60 unexpected: got output %0d/%0d, expected none", w_b0, w_b1);
         end else begin
            e = sb60.pop_front();
            check("b0_60 stream", w_b0, e.b0);
            check("b1_60 stream", w_b1, e.b1);
         end
      end
      acc = w_in_valid && w_in_ready;
      if (acc) sb60.push_back(gs_ref(w_a0, w_a1, w_y, w_q, w_halve));
      @(posedge clk);
      #1;
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      int lat;
      a0 = v.a0; a1 = v.a1; y = v.y; halve = v.h; q = 8'd131; mu = 9'd500;
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", idx), in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check($sformatf("vec%0d latency", idx), lat, GsLatency);
      check($sformatf("vec%0d B0", idx), b0, v.b0);
      check($sformatf("vec%0d B1", idx), b1, v.b1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic acc;
      int   sent, out_base;

      vecs[0] = '{8'd5,   8'd3,   8'd4,   1'b0, 8'd8,   8'd8};
      vecs[1] = '{8'd3,   8'd5,   8'd4,   1'b0, 8'd8,   8'd123};
      vecs[2] = '{8'd130, 8'd130, 8'd130, 1'b0, 8'd129, 8'd0};
      vecs[3] = '{8'd130, 8'd0,   8'd130, 1'b0, 8'd130, 8'd1};
      vecs[4] = '{8'd5,   8'd3,   8'd4,   1'b1, 8'd4,   8'd4};
      vecs[5] = '{8'd130, 8'd130, 8'd7,   1'b1, 8'd130, 8'd0};
      vecs[6] = '{8'd100, 8'd31,  8'd9,   1'b0, 8'd0,   8'd97};
      vecs[7] = '{8'd7,   8'd2,   8'd0,   1'b0, 8'd9,   8'd0};
      vecs[8] = '{8'd3,   8'd5,   8'd4,   1'b1, 8'd4,   8'd127};

      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; halve = 1'b0;
      a0 = '0; a1 = '0; y = '0; q = 8'd131; mu = 9'd500;
      w_in_valid = 1'b0; w_out_ready = 1'b1;
      new_vec60();
      @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset B0", b0, 0);
      check("reset B1", b1, 0);
      check("reset in_ready", in_ready, 1);
      check("reset out_valid60", w_out_valid, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) apply_vec(vecs[i], i);

      // Backpressure: six back-to-back inputs, output blocked in cycles 4..6.
      q = 8'd131; mu = 9'd500;
      new_vec8(1'b0);
      sent = 0;
      out_base = n_out8;
      for (int c = 0; c < 20; c++) begin
         in_valid  = (sent < 6);
         out_ready = !(c >= 4 && c <= 6);
         cycle8(acc);
         if (c >= 4 && c <= 6) check($sformatf("stall in_ready c%0d", c), last_in_ready, 0);
         if (acc) begin
            sent++;
            new_vec8(1'b0);
         end
      end
      in_valid = 1'b0;
      check("bp outputs", n_out8 - out_base, 6);
      check("bp leftovers", sb8.size(), 0);

      // Random 8-bit soak with a fresh modulus per transaction.
      new_vec8(1'b1);
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         cycle8(acc);
         if (acc) new_vec8(1'b1);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (8) cycle8(acc);
      check("soak8 drained", sb8.size(), 0);

      // Reset with a full, stalled pipe.
      q = 8'd131; mu = 9'd500;
      new_vec8(1'b0);
      in_valid = 1'b1;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cycle8(acc);
         if (acc) new_vec8(1'b0);
      end
      check("pre-reset out_valid", out_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async reset out_valid", out_valid, 0);
      check("async reset B0", b0, 0);
      check("async reset B1", b1, 0);
      check("async reset in_ready", in_ready, 1);
      sb8.delete();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      apply_vec(vecs[1], 100);

      // Random 60-bit soak.
      new_vec60();
      for (int c = 0; c < 300; c++) begin
         w_in_valid  = ($urandom_range(0, 9) < 7);
         w_out_ready = ($urandom_range(0, 9) < 6);
         cycle60(acc);
         if (acc) new_vec60();
      end
      w_in_valid = 1'b0;
      w_out_ready = 1'b1;
      repeat (8) cycle60(acc);
      check("soak60 drained", sb60.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
